// File: rtl/ahblite_interconnect_slaveport.sv
// ahblite_interconnect_slaveport
// Per-slave arbitration and multiplexing stage of an AHB-lite interconnect.
// Grants one of MASTER master ports to a single slave with round-robin
// fairness, keeps the grant through bursts and locked sequences, and
// steers the slave response back to the data-phase owner. A master whose
// next address loses arbitration while its read completes gets that read
// response parked in a per-master hold buffer until it is granted again.
module ahblite_interconnect_slaveport #(
  parameter int MASTER      = 2,
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
) (
  input  logic                                  HCLK,
  input  logic                                  HRESETn,
  // master side
  input  logic [MASTER-1:0]                     mst_HSEL_i,
  input  logic [MASTER-1:0][1:0]                mst_HTRANS_i,
  input  logic [MASTER-1:0][2:0]                mst_HBURST_i,
  input  logic [MASTER-1:0][2:0]                mst_HSIZE_i,
  input  logic [MASTER-1:0]                     mst_HWRITE_i,
  input  logic [MASTER-1:0][HADDR_WIDTH-1:0]    mst_HADDR_i,
  input  logic [MASTER-1:0][HDATA_WIDTH-1:0]    mst_HWDATA_i,
  input  logic [MASTER-1:0]                     mst_HMASTLOCK_i,
  input  logic [MASTER-1:0][6:0]                mst_HPROT_i,
  output logic [MASTER-1:0]                     mst_HREADYOUT_o,
  output logic [MASTER-1:0]                     mst_HRESP_o,
  output logic [MASTER-1:0][HDATA_WIDTH-1:0]    mst_HRDATA_o,
  // slave side
  output logic                                  HSEL_o,
  output logic [1:0]                            HTRANS_o,
  output logic [2:0]                            HBURST_o,
  output logic [2:0]                            HSIZE_o,
  output logic                                  HWRITE_o,
  output logic [HADDR_WIDTH-1:0]                HADDR_o,
  output logic [HDATA_WIDTH-1:0]                HWDATA_o,
  output logic                                  HMASTLOCK_o,
  output logic [6:0]                            HPROT_o,
  output logic                                  HREADY_o,
  input  logic                                  HREADYOUT_i,
  input  logic                                  HRESP_i,
  input  logic [HDATA_WIDTH-1:0]                HRDATA_i
);

  localparam int         IW     = (MASTER > 1) ? $clog2(MASTER) : 1;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] SEQ    = 2'b11;

  logic [IW-1:0]                        addr_q, addr_d;
  logic [IW-1:0]                        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]                        data_q, data_d;
  logic                                 dval_q, dval_d;
  logic [MASTER-1:0]                    hold_v_q, hold_v_d;
  logic [MASTER-1:0]                    hold_resp_q, hold_resp_d;
  logic [MASTER-1:0][HDATA_WIDTH-1:0]   hold_data_q, hold_data_d;

  logic [IW-1:0]                        addr_sel;
  logic                                 found;
  logic                                 locked;
  logic [MASTER-1:0]                    req;
  logic [MASTER-1:0]                    acc;
  logic [MASTER-1:0]                    own;

  // Decode per-master requests and whether the current owner must keep the bus.
  always_comb begin
    for (int m = 0; m < MASTER; m++) begin
      req[m] = mst_HSEL_i[m] & (mst_HTRANS_i[m] != IDLE);
    end
    locked = req[addr_q] & ((mst_HTRANS_i[addr_q] == SEQ) |
                            (mst_HTRANS_i[addr_q] == BUSY) |
                            mst_HMASTLOCK_i[addr_q]);
  end

  // Pick the address-phase owner: hold on wait states and locks, else round robin.
  always_comb begin
    addr_sel = addr_q;
    found    = 1'b0;
    if (!HRESETn) begin
      // while in reset the bus is parked on master 0
      addr_sel = '0;
    end else if (HREADYOUT_i && !locked) begin
      for (int k = 0; k < MASTER; k++) begin
        if (!found && req[(int'(rr_ptr_q) + k) % MASTER]) begin
          found    = 1'b1;
          addr_sel = IW'((int'(rr_ptr_q) + k) % MASTER);
        end
      end
    end
  end

  // Per-master accept/ownership flags and response steering.
  always_comb begin
    for (int m = 0; m < MASTER; m++) begin
      acc[m] = (addr_sel == IW'(m)) & HREADYOUT_i;
      own[m] = dval_q & (data_q == IW'(m));
      if (hold_v_q[m]) begin
        mst_HREADYOUT_o[m] = acc[m];
      end else if (req[m] && !acc[m]) begin
        mst_HREADYOUT_o[m] = 1'b0;
      end else if (own[m]) begin
        mst_HREADYOUT_o[m] = HREADYOUT_i;
      end else begin
        mst_HREADYOUT_o[m] = 1'b1;
      end
      mst_HRESP_o[m]  = hold_v_q[m] ? hold_resp_q[m] : (own[m] & HRESP_i);
      mst_HRDATA_o[m] = hold_v_q[m] ? hold_data_q[m] : HRDATA_i;
    end
  end

  // Slave-side command mux follows the address owner, write data the data owner.
  always_comb begin
    HSEL_o      = mst_HSEL_i[addr_sel];
    HTRANS_o    = req[addr_sel] ? mst_HTRANS_i[addr_sel] : IDLE;
    HBURST_o    = mst_HBURST_i[addr_sel];
    HSIZE_o     = mst_HSIZE_i[addr_sel];
    HWRITE_o    = mst_HWRITE_i[addr_sel];
    HADDR_o     = mst_HADDR_i[addr_sel];
    HMASTLOCK_o = mst_HMASTLOCK_i[addr_sel];
    HPROT_o     = mst_HPROT_i[addr_sel];
    HWDATA_o    = mst_HWDATA_i[data_q];
    HREADY_o    = HREADYOUT_i;
  end

  // Next-state for grant, round-robin pointer, data phase and hold buffers.
  always_comb begin
    addr_d      = addr_q;
    rr_ptr_d    = rr_ptr_q;
    data_d      = data_q;
    dval_d      = dval_q;
    hold_v_d    = hold_v_q;
    hold_resp_d = hold_resp_q;
    hold_data_d = hold_data_q;
    if (HREADYOUT_i) begin
      addr_d = addr_sel;
      if (found) begin
        rr_ptr_d = IW'((int'(addr_sel) + 1) % MASTER);
      end
      dval_d = req[addr_sel] & mst_HTRANS_i[addr_sel][1];
      data_d = addr_sel;
    end
    for (int m = 0; m < MASTER; m++) begin
      // a completing response for a master that is stalled on its next
      // address is parked; it is released when that address is accepted
      if (own[m] && HREADYOUT_i && req[m] && !acc[m]) begin
        hold_v_d[m]    = 1'b1;
        hold_resp_d[m] = HRESP_i;
        hold_data_d[m] = HRDATA_i;
      end else if (acc[m]) begin
        hold_v_d[m] = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q      <= '0;
      rr_ptr_q    <= '0;
      data_q      <= '0;
      dval_q      <= 1'b0;
      hold_v_q    <= '0;
      hold_resp_q <= '0;
      hold_data_q <= '0;
    end else begin
      addr_q      <= addr_d;
      rr_ptr_q    <= rr_ptr_d;
      data_q      <= data_d;
      dval_q      <= dval_d;
      hold_v_q    <= hold_v_d;
      hold_resp_q <= hold_resp_d;
      hold_data_q <= hold_data_d;
    end
  end

endmodule

// File: tb/tb_ahblite_interconnect_slaveport.sv
// Bench for ahblite_interconnect_slaveport: directed scenarios followed by
// randomized traffic, all compared against a behavioural model each cycle.
module tb_ahblite_interconnect_slaveport;

  localparam int M  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [M-1:0]          hsel, hwrite, hlock;
  logic [M-1:0][1:0]     htrans;
  logic [M-1:0][2:0]     hburst, hsize;
  logic [M-1:0][AW-1:0]  haddr;
  logic [M-1:0][DW-1:0]  hwdata;
  logic [M-1:0][6:0]     hprot;
  logic                  hreadyout, hresp;
  logic [DW-1:0]         hrdata;

  logic [M-1:0]          o_rdy, o_resp;
  logic [M-1:0][DW-1:0]  o_rdata;
  logic                  o_hsel, o_hwrite, o_hlock, o_hready;
  logic [1:0]            o_htrans;
  logic [2:0]            o_hburst, o_hsize;
  logic [AW-1:0]         o_haddr;
  logic [DW-1:0]         o_hwdata;
  logic [6:0]            o_hprot;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int            m_owner, m_next, m_downer;
  bit            m_dval;
  bit            m_hv [M];
  bit            m_hr [M];
  logic [DW-1:0] m_hd [M];
  int            e_sel;
  bit            e_new;
  bit            e_rdy [M];

  ahblite_interconnect_slaveport #(.MASTER(M), .HADDR_WIDTH(AW), .HDATA_WIDTH(DW)) dut (
    .HCLK(clk), .HRESETn(rstn),
    .mst_HSEL_i(hsel), .mst_HTRANS_i(htrans), .mst_HBURST_i(hburst),
    .mst_HSIZE_i(hsize), .mst_HWRITE_i(hwrite), .mst_HADDR_i(haddr),
    .mst_HWDATA_i(hwdata), .mst_HMASTLOCK_i(hlock), .mst_HPROT_i(hprot),
    .mst_HREADYOUT_o(o_rdy), .mst_HRESP_o(o_resp), .mst_HRDATA_o(o_rdata),
    .HSEL_o(o_hsel), .HTRANS_o(o_htrans), .HBURST_o(o_hburst), .HSIZE_o(o_hsize),
    .HWRITE_o(o_hwrite), .HADDR_o(o_haddr), .HWDATA_o(o_hwdata),
    .HMASTLOCK_o(o_hlock), .HPROT_o(o_hprot), .HREADY_o(o_hready),
    .HREADYOUT_i(hreadyout), .HRESP_i(hresp), .HRDATA_i(hrdata)
  );

  always #5 clk = ~clk;

  function automatic bit mreq(int m);
    return hsel[m] && (htrans[m] != 2'b00);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_next = 0; m_downer = 0; m_dval = 0;
    for (int m = 0; m < M; m++) begin
      m_hv[m] = 0; m_hr[m] = 0; m_hd[m] = '0;
    end
  endtask

  // Decide who owns the address bus this cycle and what every master sees.
  task automatic model_eval();
    bit keep;
    e_sel = m_owner;
    e_new = 0;
    keep  = mreq(m_owner) &&
            (htrans[m_owner] == 2'b11 || htrans[m_owner] == 2'b01 || hlock[m_owner]);
    if (!rstn) e_sel = 0;
    else if (hreadyout && !keep) begin
      for (int k = 0; k < M; k++) begin
        if (!e_new && mreq((m_next + k) % M)) begin
          e_sel = (m_next + k) % M;
          e_new = 1;
        end
      end
    end
    for (int m = 0; m < M; m++) begin
      bit accepted, owner;
      accepted = (e_sel == m) && hreadyout;
      owner    = m_dval && (m_downer == m);
      if (m_hv[m])                    e_rdy[m] = accepted;
      else if (mreq(m) && !accepted)  e_rdy[m] = 0;
      else if (owner)                 e_rdy[m] = hreadyout;
      else                            e_rdy[m] = 1;
    end
  endtask

  task automatic model_clock();
    if (rstn && hreadyout) begin
      for (int m = 0; m < M; m++) begin
        if (m_dval && m_downer == m && mreq(m) && e_sel != m) begin
          m_hv[m] = 1; m_hr[m] = hresp; m_hd[m] = hrdata;
        end else if (e_sel == m) begin
          m_hv[m] = 0;
        end
      end
      m_dval   = mreq(e_sel) && htrans[e_sel][1];
      m_downer = e_sel;
      m_owner  = e_sel;
      if (e_new) m_next = (e_sel + 1) % M;
    end
  endtask

  // Let combinational outputs settle and compare all of them to the model.
  task automatic settle();
    logic [M-1:0] er, ep;
    #1;
    model_eval();
    for (int m = 0; m < M; m++) begin
      bit owner;
      owner = m_dval && (m_downer == m);
      er[m] = e_rdy[m];
      ep[m] = m_hv[m] ? m_hr[m] : (owner && hresp);
      chk($sformatf("rdata%0d", m), o_rdata[m], m_hv[m] ? m_hd[m] : hrdata);
    end
    chk("rdy", o_rdy, er);
    chk("resp", o_resp, ep);
    chk("htrans", o_htrans, mreq(e_sel) ? htrans[e_sel] : 2'b00);
    chk("haddr", o_haddr, haddr[e_sel]);
    chk("cmd", {o_hsel, o_hwrite, o_hlock, o_hburst, o_hsize, o_hprot},
               {hsel[e_sel], hwrite[e_sel], hlock[e_sel], hburst[e_sel], hsize[e_sel], hprot[e_sel]});
    chk("hwdata", o_hwdata, hwdata[m_downer]);
    chk("hready", o_hready, hreadyout);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_all();
    hsel = '0; htrans = '0; hlock = '0;
  endtask

  task automatic setm(input int m, input logic [1:0] tr, input logic [2:0] bu,
                      input bit wr, input logic [31:0] ad, input bit lk);
    hsel[m] = 1'b1; htrans[m] = tr; hburst[m] = bu; hsize[m] = 3'b010;
    hwrite[m] = wr; haddr[m] = ad; hwdata[m] = ad + 32'h1000_0000;
    hlock[m] = lk; hprot[m] = 7'h03;
  endtask

  task automatic do_reset();
    rstn = 1'b0; idle_all(); hreadyout = 1'b1; hresp = 1'b0;
    model_reset();
    settle();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; hsel = '0; htrans = '0; hburst = '0; hsize = '0; hwrite = '0;
    haddr = '0; hwdata = '0; hlock = '0; hprot = '0;
    hreadyout = 1'b1; hresp = 1'b0; hrdata = '0;
    @(negedge clk);

    // reset state
    do_reset();
    settle();
    chk("reset_rdy", o_rdy, 2'b11);
    chk("reset_htrans", o_htrans, 2'b00);
    tick();

    // single master read with one wait state
    setm(0, 2'b10, 3'b000, 0, 32'h100, 0);
    settle(); chk("t1_haddr", o_haddr, 32'h100); chk("t1_htrans", o_htrans, 2'b10); tick();
    idle_all(); hreadyout = 1'b0;
    settle(); chk("t1_wait", o_rdy[0], 1'b0); tick();
    hreadyout = 1'b1; hrdata = 32'h1234_5678;
    settle(); chk("t1_done", o_rdy[0], 1'b1); chk("t1_data", o_rdata[0], 32'h1234_5678); tick();

    // two masters together: 0 first, then 1, then 0 again
    do_reset();
    setm(0, 2'b10, 3'b000, 0, 32'h200, 0); setm(1, 2'b10, 3'b000, 0, 32'h300, 0);
    hrdata = 32'h0000_0001;
    settle(); chk("t2_first", o_haddr, 32'h200); chk("t2_stall1", o_rdy[1], 1'b0); tick();
    hsel[0] = 0; htrans[0] = 2'b00; hrdata = 32'h0000_0002;
    settle(); chk("t2_second", o_haddr, 32'h300); tick();
    setm(0, 2'b10, 3'b000, 0, 32'h204, 0); setm(1, 2'b10, 3'b000, 0, 32'h304, 0);
    hrdata = 32'h0000_0003;
    settle(); chk("t2_third", o_haddr, 32'h204); chk("t2_hold1", o_rdy[1], 1'b0); tick();
    hsel[0] = 0; htrans[0] = 2'b00; hrdata = 32'h0000_0004;
    settle(); chk("t2_rel1", o_rdy[1], 1'b1); chk("t2_reldata", o_rdata[1], 32'h0000_0003); tick();
    idle_all(); settle(); tick();

    // INCR4 burst keeps the bus against a waiting master
    do_reset();
    setm(0, 2'b10, 3'b011, 0, 32'h400, 0); setm(1, 2'b10, 3'b000, 0, 32'h500, 0);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) setm(0, 2'b11, 3'b011, 0, 32'h400 + 32'(4 * b), 0);
      hrdata = 32'hB000_0000 + 32'(b);
      settle();
      chk("t3_beat", o_haddr, 32'h400 + 32'(4 * b));
      chk("t3_stall1", o_rdy[1], 1'b0);
      tick();
    end
    hsel[0] = 0; htrans[0] = 2'b00;
    settle(); chk("t3_m1", o_haddr, 32'h500); chk("t3_m1rdy", o_rdy[1], 1'b1); tick();
    idle_all(); settle(); tick();

    // back-to-back reads lose arbitration: read data is held
    do_reset();
    setm(0, 2'b10, 3'b000, 0, 32'h600, 0); setm(1, 2'b10, 3'b000, 0, 32'h700, 0);
    settle(); tick();
    setm(0, 2'b10, 3'b000, 0, 32'h604, 0); hrdata = 32'hA5A5_0000;
    settle(); chk("t4_m1", o_haddr, 32'h700); chk("t4_stall0", o_rdy[0], 1'b0); tick();
    hsel[1] = 0; htrans[1] = 2'b00; hrdata = 32'hDEAD_BEEF;
    settle();
    chk("t4_rel0", o_rdy[0], 1'b1); chk("t4_held", o_rdata[0], 32'hA5A5_0000);
    chk("t4_m1data", o_rdata[1], 32'hDEAD_BEEF); chk("t4_addr", o_haddr, 32'h604);
    tick();
    idle_all(); settle(); tick();

    // locked sequence on master 1
    do_reset();
    setm(1, 2'b10, 3'b000, 0, 32'h800, 1);
    settle(); tick();
    setm(1, 2'b10, 3'b000, 0, 32'h804, 1); setm(0, 2'b10, 3'b000, 1, 32'h900, 0);
    settle(); chk("t5_lock1", o_haddr, 32'h804); chk("t5_stall0a", o_rdy[0], 1'b0); tick();
    setm(1, 2'b10, 3'b000, 0, 32'h808, 1);
    settle(); chk("t5_lock2", o_haddr, 32'h808); chk("t5_stall0b", o_rdy[0], 1'b0); tick();
    hsel[1] = 0; htrans[1] = 2'b00; hlock[1] = 0;
    settle(); chk("t5_m0", o_haddr, 32'h900); tick();
    idle_all();
    settle(); chk("t5_wdata", o_hwdata, 32'h1000_0900); tick();

    // two-cycle ERROR response to master 1
    do_reset();
    setm(1, 2'b10, 3'b000, 0, 32'hA00, 0);
    settle(); tick();
    idle_all(); hreadyout = 1'b0; hresp = 1'b1;
    settle(); chk("t6_err1_resp", o_resp, 2'b10); chk("t6_err1_rdy", o_rdy, 2'b01); tick();
    hreadyout = 1'b1;
    settle(); chk("t6_err2_resp", o_resp, 2'b10); chk("t6_err2_rdy", o_rdy, 2'b11); tick();
    hresp = 1'b0;

    // reset in the middle of a burst
    setm(0, 2'b10, 3'b011, 0, 32'hB00, 0); settle(); tick();
    setm(0, 2'b11, 3'b011, 0, 32'hB04, 0); settle(); tick();
    setm(0, 2'b11, 3'b011, 0, 32'hB08, 0); hreadyout = 1'b0;
    rstn = 1'b0; idle_all(); model_reset();
    settle(); chk("t7_htrans", o_htrans, 2'b00); chk("t7_rdy", o_rdy, 2'b11); tick();
    rstn = 1'b1; hreadyout = 1'b1;
    settle(); tick();

    // randomized traffic; a master only changes its command once accepted
    for (int c = 0; c < 800; c++) begin
      for (int m = 0; m < M; m++) begin
        if (e_rdy[m]) begin
          hsel[m]   = ($urandom_range(0, 3) != 0);
          htrans[m] = 2'($urandom_range(0, 3));
          hburst[m] = 3'($urandom_range(0, 7));
          hsize[m]  = 3'($urandom_range(0, 2));
          hwrite[m] = 1'($urandom_range(0, 1));
          haddr[m]  = $urandom;
          hwdata[m] = $urandom;
          hlock[m]  = ($urandom_range(0, 7) == 0);
          hprot[m]  = 7'($urandom_range(0, 127));
        end
      end
      hreadyout = ($urandom_range(0, 3) != 0);
      hresp     = ($urandom_range(0, 9) == 0);
      hrdata    = $urandom;
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahblite_interconnect_slaveport.md
Name: ahblite_interconnect_slaveport

Overview:
- Per-slave arbitration and multiplexing stage, directly downstream of the interconnect master ports.
- Takes the address-phase command and per-slave HSEL from MASTER master ports and grants one master at a time to a single AHB-lite slave, with round-robin fairness and burst/lock retention.
- Routes the slave's HREADYOUT/HRESP/HRDATA back to the data-phase owner.
- Holds completed read responses for masters whose next address lost arbitration.

Parameters:
MASTER, 2, number of master ports arbitrated (1..16)
HADDR_WIDTH, 32, address width
HDATA_WIDTH, 32, data width

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous, active-low
mst_HSEL_i  in  MASTER  per-master select for this slave
mst_HTRANS_i  in  MASTER x 2  per-master HTRANS
mst_HBURST_i  in  MASTER x 3  per-master HBURST
mst_HSIZE_i  in  MASTER x 3  per-master HSIZE
mst_HWRITE_i  in  MASTER  per-master HWRITE
mst_HADDR_i  in  MASTER x HADDR_WIDTH  per-master HADDR
mst_HWDATA_i  in  MASTER x HDATA_WIDTH  per-master HWDATA
mst_HMASTLOCK_i  in  MASTER  per-master HMASTLOCK
mst_HPROT_i  in  MASTER x 7  per-master HPROT
mst_HREADYOUT_o  out  MASTER  per-master HREADY
mst_HRESP_o  out  MASTER  per-master HRESP
mst_HRDATA_o  out  MASTER x HDATA_WIDTH  per-master HRDATA
HSEL_o, HTRANS_o[2], HBURST_o[3], HSIZE_o[3], HWRITE_o, HADDR_o[HADDR_WIDTH], HWDATA_o[HDATA_WIDTH], HMASTLOCK_o, HPROT_o[7]  out  slave-side command/write data
HREADY_o  out  1  slave HREADY input; equals HREADYOUT_i
HREADYOUT_i, HRESP_i  in  1  slave response
HRDATA_i  in  HDATA_WIDTH  slave read data

Behaviour:
- req[m] = mst_HSEL_i[m] & (mst_HTRANS_i[m] != IDLE).
- State registers:
  - addr_q: address owner index, reset 0.
  - rr_ptr: reset 0.
  - dval_q/data_q: data-phase valid/owner, reset 0/0.
  - hold_v[m]/hold_resp[m]/hold_data[m]: reset 0.
- Lock: locked = req[addr_q] & (HTRANS is SEQ or BUSY, or HMASTLOCK=1) for addr_q.
- Address select addr_sel (combinational):
  - HREADYOUT_i=0: addr_q.
  - Else if locked: addr_q.
  - Else: first requester scanning rr_ptr, rr_ptr+1, … mod MASTER.
  - No requester: addr_q (park).
- On HREADYOUT_i=1:
  - addr_q <= addr_sel.
  - If a new grant was made, rr_ptr <= (addr_sel+1) mod MASTER.
  - dval_q <= req[addr_sel] & HTRANS[1] of addr_sel; data_q <= addr_sel.
- Slave outputs = addr_sel master's command; HTRANS_o = req[addr_sel] ? its HTRANS : IDLE; HSEL_o = mst_HSEL_i[addr_sel].
- HWDATA_o = mst_HWDATA_i[data_q]; zero latency.
- acc[m] = (addr_sel==m) & HREADYOUT_i.
- mst_HREADYOUT_o[m], priority order:
  - hold_v[m]: acc[m].
  - Else req[m] & ~acc[m]: 0.
  - Else dval_q & data_q==m: HREADYOUT_i.
  - Else: 1.
- Hold capture: dval_q & data_q==m & HREADYOUT_i & req[m] & ~acc[m] → hold_v[m]<=1, hold_data<=HRDATA_i, hold_resp<=HRESP_i.
- Hold release: acc[m] clears hold_v[m]. Capture and release never coincide for one m.
- mst_HRESP_o[m]: hold_v ? hold_resp : (dval_q & data_q==m) ? HRESP_i : 0.
- mst_HRDATA_o[m]: hold_v ? hold_data : HRDATA_i.
- First ERROR cycle (HRESP_i=1, HREADYOUT_i=0) is forwarded unchanged to the data owner.
- Masters must keep their command stable while their HREADYOUT is low.
- Undefined-length INCR is retained through SEQ/BUSY; a NONSEQ from the owner reopens arbitration.
- MASTER=1: degenerates to pass-through; holds never set.
- Reset mid-transfer: all state returns to reset values immediately; HTRANS_o is IDLE unless master 0 is requesting.

Test Plan:
- Single master 0, NONSEQ read 0x100, slave 1 wait state → HADDR_o=0x100 cycle 0; mst_HREADYOUT_o[0]=0 then 1 with HRDATA=slave data.
- Masters 0 and 1 issue NONSEQ together after reset → 0 granted first, 1 stalled one transfer, then granted; rr_ptr alternates 1,0.
- Master 0 INCR4 (NONSEQ+3 SEQ) while master 1 requests → 4 contiguous beats from 0, then master 1 NONSEQ granted.
- Master 0 back-to-back NONSEQ reads vs waiting master 1 → master 1 granted; master 0 read data 0xA5A5_0000 held, returned with HREADYOUT=1 on its next grant.
- HMASTLOCK=1 on master 1 across 3 SINGLE transfers → master 0 stalled until lock drops.
- Slave ERROR response to master 1 → HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1 seen only on port 1; assert HRESETn mid-burst → HTRANS_o=IDLE, all mst_HREADYOUT_o=1.
